aes_key_sched_multi: RTL and testbench
======================================

AES_KEY_SCHED_MULTI -- requirements
Module: aes_key_sched_multi

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, meaning the largest supported key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk_i  in  1  clock.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 start_i  in  1  request to expand key_i; sampled only in IDLE, DONE or ERR.
REQ-006 key_len_i  in  2  key length select: 0 = AES-128 (Nk=4, Nr=10), 1 = AES-192 (Nk=6, Nr=12), 2 = AES-256 (Nk=8, Nr=14), 3 = illegal.
REQ-007 key_i  in  256  cipher key, left-aligned; w[0] = key_i[255:224]; unused low bits are ignored.
REQ-008 busy_o  out  1  high in LOAD and EXPAND.
REQ-009 done_o  out  1  one-cycle pulse when the last word has been written.
REQ-010 keys_valid_o  out  1  high while the schedule is complete and unchanged.
REQ-011 err_o  out  1  one-cycle pulse when a start is rejected.
REQ-012 rk_idx_i  in  4  round-key read index, 0..Nr.
REQ-013 rk_o  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].

Function
REQ-014 FSM states SHALL be IDLE, LOAD, EXPAND, DONE and ERR.
- IDLE/DONE/ERR + start_i with a legal length (Nk <= MAX_NK) -> LOAD.
- Same condition with an illegal length -> ERR, err_o pulses.
REQ-015 On accepting a start, the block SHALL latch key_len_i and key_i and deassert keys_valid_o in the same cycle.
REQ-016 LOAD SHALL write w[0..Nk-1] in one cycle, then go to EXPAND with i = Nk.
REQ-017 EXPAND SHALL write exactly one word per cycle, in FIPS-197 order:
- temp = w[i-1].
- If i mod Nk = 0: temp = SubWord(RotWord(temp)) xor {rcon, 24'h0}.
- Else if Nk = 8 and i mod Nk = 4: temp = SubWord(temp).
- w[i] = w[i-Nk] xor temp.
REQ-018 i mod Nk SHALL come from a wrapping counter (0..Nk-1), not a divider.
REQ-019 rcon SHALL start at 8'h01 and update by xtime after each i mod Nk = 0 step, so the sequence is 01, 02, …, 80, 1b, 36.
REQ-020 EXPAND SHALL end after w[4*Nr+3] (43/51/59), taking 40/46/52 EXPAND cycles.
- The next cycle is DONE: done_o pulses once and keys_valid_o rises.
REQ-021 Latency from the start_i accept edge to done_o SHALL be 42/48/54 cycles for 128/192/256.
REQ-022 A start_i during LOAD or EXPAND SHALL be ignored, with no error and no effect on the schedule.
REQ-023 A start_i in DONE SHALL restart expansion, and keys_valid_o SHALL fall in the accept cycle.
REQ-024 rk_o SHALL be registered with a 1-cycle read latency.
- If rk_idx_i > Nr of the latched mode, or keys_valid_o is low, rk_o SHALL be 128'h0.
REQ-025 ERR SHALL behave as IDLE except that it is entered by rejection; keys_valid_o SHALL stay 0.

Reset
REQ-026 Reset SHALL produce: state IDLE, busy_o 0, done_o 0, keys_valid_o 0, err_o 0, rk_o 0, counters 0, rcon 8'h01.
REQ-027 Reset during LOAD or EXPAND SHALL abort the expansion; the word storage is not reset.
REQ-028 A reset asserted together with start_i SHALL take priority.

Configuration
REQ-029 Macro AES_KEY_SCHED_ZEROIZE_EN:
- Defined: adds input zeroize_i (1 bit). When high, all word storage and latched key registers SHALL be cleared to 0 within 1 cycle, the FSM SHALL go to IDLE, and keys_valid_o SHALL drop. zeroize_i has priority over start_i.
- Undefined: no port, no clear logic, storage holds its last values.

Structure
REQ-030 Package aes_pkg SHALL hold:
- the AES key_len_e enum (KL128, KL192, KL256);
- the SBOX constant;
- the Nk/Nr lookup functions;
- the xtime function;
- the state enum.
REQ-031 SubWord SHALL be one sub-module, aes_subword: four combinational sbox lookups, 32-bit in and out, instantiated once.
REQ-032 Word storage depth SHALL be 4*(Nr_max+1) words, where Nr_max is the Nr for MAX_NK.

Verification
REQ-033 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done_o at cycle 42; rk_idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done_o at cycle 48; rk_idx 12 -> e98ba06f448c773c8ecc720401002202.
REQ-035 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done_o at cycle 54; rk_idx 14 low word 706c631e; rk_idx 0 = key_i[255:128].
REQ-036 Illegal and unsupported lengths:
- key_len_i = 3 -> err_o pulses 1 cycle, keys_valid_o stays 0.
- MAX_NK = 4 with key_len_i = 2 -> err_o pulses.
REQ-037 start_i repeated at EXPAND cycle 10 -> ignored, and the AES-128 result is unchanged; reset at EXPAND cycle 20 -> IDLE, all outputs 0.
REQ-038 With AES_KEY_SCHED_ZEROIZE_EN defined, zeroize_i high in DONE -> keys_valid_o 0 next cycle, and rk_o for index 0 reads 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length and FSM enums, S-box table,
// Nk/Nr lookups and the GF(2^8) xtime helper.
package aes_pkg;

  typedef enum logic [1:0] {
    KL128   = 2'd0,
    KL192   = 2'd1,
    KL256   = 2'd2,
    KL_RSVD = 2'd3
  } key_len_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXPAND = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_e;

  // Byte 0x00 maps to the most significant byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nk_of(key_len_e kl);
    case (kl)
      KL128:   return 4;
      KL192:   return 6;
      KL256:   return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int nr_of(key_len_e kl);
    return nk_of(kl) + 6;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_multi_if.sv
// Request/status/round-key bundle for aes_key_sched_multi.
// AES_KEY_SCHED_ZEROIZE_EN adds the zeroize_i request line.
interface aes_key_sched_multi_if;
  logic         start_i;
  logic [1:0]   key_len_i;
  logic [255:0] key_i;
  logic [3:0]   rk_idx_i;
  logic         busy_o;
  logic         done_o;
  logic         keys_valid_o;
  logic         err_o;
  logic [127:0] rk_o;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
  logic         zeroize_i;
`endif

  modport master (
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    output zeroize_i,
`endif
    output start_i, key_len_i, key_i, rk_idx_i,
    input  busy_o, done_o, keys_valid_o, err_o, rk_o
  );

  modport slave (
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    input  zeroize_i,
`endif
    input  start_i, key_len_i, key_i, rk_idx_i,
    output busy_o, done_o, keys_valid_o, err_o, rk_o
  );
endinterface

// File: rtl/aes_subword.sv
// AES SubWord: four parallel combinational S-box lookups on a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] subbed
);
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    assign subbed[8*gi +: 8] = SBOX[word[8*gi +: 8]];
  end
endmodule

// File: rtl/aes_key_sched_multi.sv
// Iterative AES-128/192/256 key expansion, one schedule word per cycle, with a
// registered round-key read port. AES_KEY_SCHED_ZEROIZE_EN adds a storage wipe.
module aes_key_sched_multi
  import aes_pkg::*;
#(
  parameter int MAX_NK = 8
) (
  input logic clk_i,
  input logic rst_i,
  aes_key_sched_multi_if.slave bus
);
  localparam int NR_MAX = MAX_NK + 6;
  localparam int DEPTH  = 4 * (NR_MAX + 1);
  localparam int AW     = $clog2(DEPTH);

  state_e         state_reg, state_next;
  key_len_e       len_reg, len_in;
  logic [255:0]   key_reg;
  logic [31:0]    w_reg [DEPTH];
  logic [AW-1:0]  idx_reg;
  logic [2:0]     mod_reg;
  logic [7:0]     rcon_reg;
  logic           done_reg, err_reg;
  logic [127:0]   rk_reg;

  logic           wipe, idle_like, len_ok, accept, reject, last;
  int             nk_cur, nr_cur;
  logic [2:0]     nk_m1;
  logic [AW-1:0]  addr_prev, addr_back;
  logic [31:0]    prev_word, back_word, sub_in, sub_out, temp, new_word;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
  assign wipe = bus.zeroize_i;
`else
  assign wipe = 1'b0;
`endif

  assign len_in    = key_len_e'(bus.key_len_i);
  assign idle_like = state_reg inside {IDLE, DONE, ERR};
  assign len_ok    = (len_in != KL_RSVD) && (nk_of(len_in) <= MAX_NK);
  assign accept    = idle_like && bus.start_i && len_ok && !wipe;
  assign reject    = idle_like && bus.start_i && !len_ok && !wipe;

  assign nk_cur = nk_of(len_reg);
  assign nr_cur = nr_of(len_reg);
  assign nk_m1  = 3'(nk_cur - 1);
  assign last   = (idx_reg == AW'(4 * nr_cur + 3));

  // w[i-1] and w[i-Nk] feed the recurrence for the word being written.
  assign addr_prev = idx_reg - AW'(1);
  assign addr_back = idx_reg - AW'(nk_cur);
  assign prev_word = w_reg[addr_prev];
  assign back_word = w_reg[addr_back];

  aes_subword u_subword (
    .word   (sub_in),
    .subbed (sub_out)
  );

  always_comb begin
    sub_in = prev_word;
    temp   = prev_word;
    if (mod_reg == 3'd0) begin
      sub_in = {prev_word[23:0], prev_word[31:24]};
      temp   = sub_out ^ {rcon_reg, 24'h0};
    end else if (len_reg == KL256 && mod_reg == 3'd4) begin
      temp   = sub_out;
    end
    new_word = back_word ^ temp;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERR: begin
        if (accept)      state_next = LOAD;
        else if (reject) state_next = ERR;
      end
      LOAD:    state_next = EXPAND;
      EXPAND:  if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (wipe) state_next = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      mod_reg   <= '0;
      rcon_reg  <= 8'h01;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == EXPAND) && last && !wipe;
      err_reg   <= reject;
      case (state_reg)
        LOAD: begin
          idx_reg  <= AW'(nk_cur);
          mod_reg  <= '0;
          rcon_reg <= 8'h01;
        end
        EXPAND: begin
          idx_reg <= idx_reg + AW'(1);
          mod_reg <= (mod_reg == nk_m1) ? 3'd0 : mod_reg + 3'd1;
          if (mod_reg == 3'd0) rcon_reg <= xtime(rcon_reg);
        end
        default: ;
      endcase
    end
  end

  // Schedule storage and the latched request survive reset on purpose.
  always_ff @(posedge clk_i) begin
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    if (bus.zeroize_i) begin
      key_reg <= '0;
      len_reg <= KL128;
      for (int j = 0; j < DEPTH; j++) w_reg[j] <= '0;
    end else
`endif
    if (!rst_i) begin
      if (accept) begin
        key_reg <= bus.key_i;
        len_reg <= len_in;
      end
      if (state_reg == LOAD) begin
        for (int j = 0; j < 8; j++)
          if (j < nk_cur) w_reg[j] <= key_reg[255 - 32*j -: 32];
      end else if (state_reg == EXPAND) begin
        w_reg[idx_reg] <= new_word;
      end
    end
  end

  logic          rk_ok;
  logic [AW-1:0] rk_base;
  logic [31:0]   rk_word [4];

  assign rk_ok   = (state_reg == DONE) && (int'(bus.rk_idx_i) <= nr_cur);
  assign rk_base = rk_ok ? AW'({bus.rk_idx_i, 2'b00}) : '0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rk
    assign rk_word[gi] = w_reg[rk_base + AW'(gi)];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || wipe || !rk_ok) rk_reg <= '0;
    else                         rk_reg <= {rk_word[0], rk_word[1], rk_word[2], rk_word[3]};
  end

  assign bus.busy_o       = (state_reg == LOAD) || (state_reg == EXPAND);
  assign bus.done_o       = done_reg;
  assign bus.keys_valid_o = (state_reg == DONE);
  assign bus.err_o        = err_reg;
  assign bus.rk_o         = rk_reg;

endmodule

// File: tb/tb_aes_key_sched_multi.sv
// Self-checking bench for aes_key_sched_multi: FIPS-197 schedules, latency,
// illegal lengths, restart/abort corners, a MAX_NK=4 instance and optional zeroize.
module tb_aes_key_sched_multi;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_key_sched_multi_if bus8();
  aes_key_sched_multi_if bus4();

  aes_key_sched_multi #(.MAX_NK(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(bus8.slave));
  aes_key_sched_multi #(.MAX_NK(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4.slave));

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0123456789abcdeffedcba9876543210};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffffffffffff};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] FULL = {128{1'b1}};
  localparam logic [127:0] LOW32 = 128'hffffffff;

  typedef struct {
    string              name;
    logic [1:0]         len;
    logic [255:0]       key;
    int                 lat;
    logic [0:3][3:0]    idx;
    logic [0:3][127:0]  rk;
    logic [0:3][127:0]  mask;
  } vec_t;

  typedef struct {
    string        name;
    logic [127:0] exp;
    logic [127:0] mask;
  } rd_t;

  vec_t vecs [3];
  int   lat_q [$];
  rd_t  rd_q  [$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_rk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Caller is at a negedge; expected value queued now, compared when rk_o appears.
  task automatic rk_read(input logic [3:0] idx, input logic [127:0] exp, input logic [127:0] mask, input string name);
    rd_t r;
    r.name = name; r.exp = exp & mask; r.mask = mask;
    rd_q.push_back(r);
    bus8.rk_idx_i = idx;
    @(negedge clk);
    r = rd_q.pop_front();
    check_rk(r.name, bus8.rk_o & r.mask, r.exp);
    $display("rk_read %s idx=%0d rk=%h", name, idx, bus8.rk_o);
  endtask

  // Start an expansion on dut8 and measure accept-edge-to-done latency.
  task automatic run_expand(input logic [1:0] len, input logic [255:0] key, input int exp_lat,
                            input int poke_at, input string tag);
    int c;
    int got;
    int err_seen;
    lat_q.push_back(exp_lat);
    bus8.key_len_i = len; bus8.key_i = key; bus8.start_i = 1'b1;
    @(negedge clk);
    bus8.start_i = 1'b0; bus8.key_i = ~key; bus8.key_len_i = 2'd3;
    c = 1; err_seen = 0;
    check({tag, " kv_low_after_accept"}, int'(bus8.keys_valid_o), 0);
    check({tag, " busy_after_accept"}, int'(bus8.busy_o), 1);
    while (!bus8.done_o && c < 200) begin
      if (c == poke_at) begin bus8.start_i = 1'b1; bus8.key_len_i = 2'd0; end
      @(negedge clk);
      c++;
      bus8.start_i = 1'b0; bus8.key_len_i = 2'd3;
      if (bus8.err_o) err_seen = 1;
    end
    got = bus8.done_o ? c : -1;
    check({tag, " latency"}, got, lat_q.pop_front());
    $display("expand %s latency=%0d", tag, got);
    if (poke_at > 0) check({tag, " no_err_on_busy_start"}, err_seen, 0);
    @(negedge clk);
    check({tag, " done_one_pulse"}, int'(bus8.done_o), 0);
    check({tag, " kv_high"}, int'(bus8.keys_valid_o), 1);
  endtask

  initial begin
    int c;
    vecs[0] = '{"aes128", 2'd0, K128, 42, {4'd0, 4'd1, 4'd10, 4'd11},
                {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0}, {FULL, FULL, FULL, FULL}};
    vecs[1] = '{"aes192", 2'd1, K192, 48, {4'd0, 4'd1, 4'd12, 4'd13},
                {128'h8e73b0f7da0e6452c810f32b809079e5, 128'h62f8ead2522c6b7bfe0c91f72402f5a5,
                 128'he98ba06f448c773c8ecc720401002202, 128'h0}, {FULL, FULL, FULL, FULL}};
    vecs[2] = '{"aes256", 2'd2, K256, 54, {4'd0, 4'd2, 4'd14, 4'd15},
                {128'h603deb1015ca71be2b73aef0857d7781, 128'h9ba354118e6925afa51a8b5f2067fcde,
                 128'h706c631e, 128'h0}, {FULL, FULL, LOW32, FULL}};

    rst = 1'b1;
    bus8.start_i = 1'b0; bus8.key_len_i = 2'd0; bus8.key_i = '0; bus8.rk_idx_i = '0;
    bus4.start_i = 1'b0; bus4.key_len_i = 2'd0; bus4.key_i = '0; bus4.rk_idx_i = '0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    bus8.zeroize_i = 1'b0; bus4.zeroize_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset busy", int'(bus8.busy_o), 0);
    check("reset done", int'(bus8.done_o), 0);
    check("reset kv", int'(bus8.keys_valid_o), 0);
    check("reset err", int'(bus8.err_o), 0);
    check_rk("reset rk", bus8.rk_o, 128'h0);
    rst = 1'b0;
    rk_read(4'd0, 128'h0, FULL, "rk_before_valid");

    for (int v = 0; v < 3; v++) begin
      run_expand(vecs[v].len, vecs[v].key, vecs[v].lat, 0, vecs[v].name);
      for (int k = 0; k < 4; k++)
        rk_read(vecs[v].idx[k], vecs[v].rk[k], vecs[v].mask[k], {vecs[v].name, " rk"});
    end

    // Restart from DONE, with a stray start during EXPAND cycle 10.
    run_expand(2'd0, K128, 42, 11, "restart_poke");
    rk_read(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, FULL, "restart_poke rk10");

    // Illegal length from DONE.
    bus8.key_len_i = 2'd3; bus8.start_i = 1'b1;
    @(negedge clk);
    bus8.start_i = 1'b0;
    check("illegal err_pulse", int'(bus8.err_o), 1);
    check("illegal kv", int'(bus8.keys_valid_o), 0);
    check("illegal busy", int'(bus8.busy_o), 0);
    @(negedge clk);
    check("illegal err_one_cycle", int'(bus8.err_o), 0);
    $display("illegal len=3 handled");
    rk_read(4'd0, 128'h0, FULL, "err rk0");

    run_expand(2'd1, K192, 48, 0, "from_err");
    rk_read(4'd12, 128'he98ba06f448c773c8ecc720401002202, FULL, "from_err rk12");

    // Reset during EXPAND cycle 20 aborts.
    bus8.key_len_i = 2'd0; bus8.key_i = K128; bus8.start_i = 1'b1;
    @(negedge clk);
    bus8.start_i = 1'b0;
    repeat (20) @(negedge clk);
    check("abort busy_before_reset", int'(bus8.busy_o), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", int'(bus8.busy_o), 0);
    check("abort done", int'(bus8.done_o), 0);
    check("abort kv", int'(bus8.keys_valid_o), 0);
    check("abort err", int'(bus8.err_o), 0);
    check_rk("abort rk", bus8.rk_o, 128'h0);
    $display("reset during expand handled");
    rk_read(4'd10, 128'h0, FULL, "abort rk10");

    // Reset coincident with start wins.
    run_expand(2'd0, K128, 42, 0, "pre_rst_start");
    bus8.key_len_i = 2'd0; bus8.start_i = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus8.start_i = 1'b0; rst = 1'b0;
    check("rst_start kv", int'(bus8.keys_valid_o), 0);
    check("rst_start busy", int'(bus8.busy_o), 0);
    @(negedge clk);
    check("rst_start stays_idle", int'(bus8.busy_o), 0);
    $display("reset with start handled");

    // MAX_NK=4 instance rejects AES-256, still expands AES-128.
    bus4.key_len_i = 2'd2; bus4.key_i = K256; bus4.start_i = 1'b1;
    @(negedge clk);
    bus4.start_i = 1'b0;
    check("nk4 aes256 err", int'(bus4.err_o), 1);
    check("nk4 aes256 busy", int'(bus4.busy_o), 0);
    lat_q.push_back(42);
    bus4.key_len_i = 2'd0; bus4.key_i = K128; bus4.start_i = 1'b1;
    @(negedge clk);
    bus4.start_i = 1'b0;
    c = 1;
    while (!bus4.done_o && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("nk4 aes128 latency", bus4.done_o ? c : -1, lat_q.pop_front());
    bus4.rk_idx_i = 4'd10;
    @(negedge clk);
    check_rk("nk4 rk10", bus4.rk_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    $display("max_nk4 latency=%0d rk10=%h", c, bus4.rk_o);

`ifdef AES_KEY_SCHED_ZEROIZE_EN
    run_expand(2'd0, K128, 42, 0, "pre_zeroize");
    bus8.zeroize_i = 1'b1;
    @(negedge clk);
    bus8.zeroize_i = 1'b0;
    check("zeroize kv", int'(bus8.keys_valid_o), 0);
    rk_read(4'd0, 128'h0, FULL, "zeroize rk0");
    $display("zeroize handled");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
